// File: rtl/multi_debouncer_if.sv
// Button/level/pulse bundle for multi_debouncer; the DUT uses the slave modport.
interface multi_debouncer_if #(
    parameter int N = 4
);
    logic [N-1:0] button_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;

    modport master (output button_i, input level_o, press_o, release_o);
    modport slave  (input button_i, output level_o, press_o, release_o);
endinterface

// File: rtl/multi_debouncer.sv
// N-channel button debouncer with registered press/release pulses.
// Define MULTI_DEBOUNCER_AUTOREPEAT_EN to add per-channel auto-repeat press pulses.
module multi_debouncer_lane #(
    parameter int CNT_W         = 16,
    parameter int STABLE_CNT    = 36864
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 4000000,
    parameter int REPEAT_PERIOD = 1000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept, rise, fall, rpt_fire;

    // Counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
        rise    = accept & sync2_q;
        fall    = accept & ~sync2_q;
        level_d = accept ? sync2_q : level_q;
        cnt_d   = ((sync2_q == level_q) || accept) ? '0 : cnt_q + CNT_W'(1);
    end

    assign press_d   = rise | rpt_fire;
    assign release_d = fall;

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             held;

    // held excludes the rise edge itself, so the count restarts at 0 in the edge-press cycle.
    always_comb begin
        held        = level_q & level_d;
        rpt_fire    = held && (rpt_q == (rpt_phase_q ? RPT_NEXT : RPT_FIRST));
        rpt_d       = rpt_q + RPT_W'(1);
        rpt_phase_d = rpt_phase_q;
        if (!held) begin
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
        end else if (rpt_fire) begin
            rpt_d       = '0;
            rpt_phase_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= button_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module multi_debouncer #(
    parameter int N             = 4,
    parameter int CNT_W         = 16,
    parameter int STABLE_CNT    = 36864,
    parameter int REPEAT_DELAY  = 4000000,
    parameter int REPEAT_PERIOD = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    multi_debouncer_if.slave   bus
);
    logic [N-1:0] level_w, press_w, release_w;

    if (N < 1 || N > 32 || STABLE_CNT < 2 ||
        longint'(STABLE_CNT) > ((64'd1 << CNT_W) - 64'd1) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("multi_debouncer: illegal parameter combination");
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        multi_debouncer_lane #(
            .CNT_W         (CNT_W),
            .STABLE_CNT    (STABLE_CNT)
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .button_i  (bus.button_i[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i])
        );
    end

    assign bus.level_o   = level_w;
    assign bus.press_o   = press_w;
    assign bus.release_o = release_w;
endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench: a window-based reference model predicts each cycle's outputs.
module tb_multi_debouncer;
    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int SC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int MAXC = 4096;

    typedef struct {
        int           cyc;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;

    logic [N-1:0] drv [MAXC];
    logic         rstv[MAXC];
    logic [N-1:0] mlevel = '0;
    int           since[N];
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    int           rise_e[N];
`endif

    multi_debouncer_if #(.N(N)) bus();

    multi_debouncer #(
        .N(N), .CNT_W(CW), .STABLE_CNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Value the debounce logic sees on edge e: button from 3 cycles back, zero while reset flushes the synchronizer.
    function automatic logic sample(input int e, input int ch);
        if (e < 3) return 1'b0;
        if (rstv[e-2] || rstv[e-3]) return 1'b0;
        return drv[e-3][ch];
    endfunction

    // Level flips on edge e when the last SC samples since the previous flip/reset all disagree with it.
    task automatic model_edge(input int e);
        exp_t x;
        logic flip;
        x.cyc = e; x.lvl = '0; x.prs = '0; x.rls = '0;
        if (rstv[e-1]) begin
            mlevel = '0;
            for (int ch = 0; ch < N; ch++) since[ch] = e;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                flip = (e - since[ch]) >= SC;
                for (int k = 0; k < SC; k++)
                    if (sample(e - k, ch) == mlevel[ch]) flip = 1'b0;
                if (flip) begin
                    mlevel[ch] = ~mlevel[ch];
                    since[ch]  = e;
                    if (mlevel[ch]) begin
                        x.prs[ch] = 1'b1;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                        rise_e[ch] = e;
`endif
                    end else begin
                        x.rls[ch] = 1'b1;
                    end
                end
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
                else if (mlevel[ch]) begin
                    int d;
                    d = e - rise_e[ch];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) x.prs[ch] = 1'b1;
                end
`endif
            end
        end
        x.lvl = mlevel;
        sb.push_back(x);
    endtask

    task automatic step(input logic r, input logic [N-1:0] b);
        if (cyc < MAXC - 2) begin
            rst = r;
            bus.button_i = b;
            drv[cyc]  = b;
            rstv[cyc] = r;
            model_edge(cyc + 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic r, input logic [N-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(r, b);
    endtask

    task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cyc=%0d got=%0d want=%0d", cyc, cur.cyc, cyc);
            end else begin
                chk("level", bus.level_o, cur.lvl);
                chk("press", bus.press_o, cur.prs);
                chk("release", bus.release_o, cur.rls);
                chk("press_and_release", bus.press_o & bus.release_o, '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int           seg[N];
        logic [N-1:0] b;
        bus.button_i = '0;
        hold(1'b1, 4'b0000, 3);
        hold(1'b0, 4'b0001, 10);                           // single press
        hold(1'b0, 4'b0011, 3); hold(1'b0, 4'b0001, 8);    // short glitch on ch1
        hold(1'b0, 4'b0101, 3); hold(1'b0, 4'b0001, 2);
        hold(1'b0, 4'b0101, 10);                           // interrupted count on ch2
        hold(1'b0, 4'b1101, 10); hold(1'b0, 4'b0101, 10);  // ch3 press then release
        hold(1'b1, 4'b0000, 2); hold(1'b0, 4'b0001, 4);
        hold(1'b1, 4'b0001, 1); hold(1'b0, 4'b0001, 10);   // reset mid-count, held through
        hold(1'b1, 4'b0000, 2); hold(1'b0, 4'b0000, 3);
        hold(1'b0, 4'b0001, 40); hold(1'b0, 4'b0000, 8);   // long hold for auto-repeat
        b = '0;
        for (int ch = 0; ch < N; ch++) seg[ch] = 1;
        for (int t = 0; t < 1500; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                seg[ch]--;
                if (seg[ch] == 0) begin
                    b[ch]   = ~b[ch];
                    seg[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                          : int'($urandom_range(1, 7));
                end
            end
            step($urandom_range(0, 199) == 0, b);
        end
        hold(1'b0, 4'b0000, 12);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
